// File: rtl/ao_vector_sequencer.sv
// Exhaustive 3-input stimulus sequencer for two (a & b) | c gate implementations.
// Each vector is held HOLD_CYCLES cycles, then y1/y2 are compared and the results are accumulated.
module ao_vector_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter bit          GOLDEN_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y1,
  input  logic       y2,
  output logic       aa,
  output logic       bb,
  output logic       cc,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] mismatch_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] vec_idx, vec_nxt;
  logic [7:0] hold_cnt, cnt_nxt;
  logic       sample_now;
  logic       clear_res;
  logic       golden;
  logic       vec_bad;

  assign golden  = (aa & bb) | cc;
  assign vec_bad = (y1 != y2) || (GOLDEN_EN && ((y1 != golden) || (y2 != golden)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_idx  <= 3'd0;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      vec_idx  <= vec_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  // Abort wins over the sample edge, so an aborted vector never reaches the results.
  always_comb begin
    state_nxt  = state;
    vec_nxt    = vec_idx;
    cnt_nxt    = hold_cnt;
    sample_now = 1'b0;
    clear_res  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = HOLD;
          vec_nxt   = 3'd0;
          cnt_nxt   = 8'd0;
          clear_res = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
          vec_nxt   = 3'd0;
          cnt_nxt   = 8'd0;
        end else if (hold_cnt == LAST_CNT) begin
          sample_now = 1'b1;
          cnt_nxt    = 8'd0;
          if (vec_idx == 3'd7) begin
            state_nxt = DONE;
            vec_nxt   = 3'd0;
          end else begin
            vec_nxt = vec_idx + 3'd1;
          end
        end else begin
          cnt_nxt = hold_cnt + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        vec_nxt   = 3'd0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      aa             <= 1'b0;
      bb             <= 1'b0;
      cc             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      mismatch_count <= 4'd0;
      fail_mask      <= 8'd0;
      first_fail_vec <= 3'd0;
    end else begin
      busy         <= (state_nxt == HOLD);
      done         <= (state_nxt == DONE);
      {aa, bb, cc} <= (state_nxt == HOLD) ? vec_nxt : 3'd0;
      if (clear_res) begin
        fail           <= 1'b0;
        mismatch_count <= 4'd0;
        fail_mask      <= 8'd0;
        first_fail_vec <= 3'd0;
      end else if (sample_now && vec_bad) begin
        fail               <= 1'b1;
        mismatch_count     <= mismatch_count + 4'd1;
        fail_mask[vec_idx] <= 1'b1;
        if (!fail) begin
          first_fail_vec <= vec_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_ao_vector_sequencer.sv
// Scoreboard bench for ao_vector_sequencer: one HOLD_CYCLES=4 instance and one HOLD_CYCLES=1 instance.
// Expected run results are queued at stimulus time and checked by per-instance monitors at run end.
module tb_ao_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] start, abort, y1, y2, aa, bb, cc, busy, done, fail;
  logic [3:0] mcnt   [2];
  logic [7:0] fmask  [2];
  logic [2:0] ffv    [2];
  logic [7:0] y1_flip[2];
  logic [7:0] y2_flip[2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit done;
    bit fail;
    int cnt;
    int mask;
    int first;
    int edges;
  } exp_t;

  exp_t exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input bit d, input bit f, input int c, input int m, input int fv, input int e);
    exp_t x;
    x.done = d; x.fail = f; x.cnt = c; x.mask = m; x.first = fv; x.edges = e;
    exp_q.push_back(x);
  endtask

  // Start pulse (optionally together with abort); returns just after the capture edge.
  task automatic applyStimulus(input int inst, input logic [7:0] f2, input bit with_abort);
    @(negedge clk);
    y2_flip[inst] = f2;
    start[inst]   = 1'b1;
    abort[inst]   = with_abort;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    abort[inst] = 1'b0;
  endtask

  task automatic waitIdle(input int inst, input int max_cycles);
    int k = 0;
    while ((busy[inst] || done[inst]) && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= max_cycles) checkOutput("wait_idle_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int    HC = (i == 0) ? 4 : 1;
    localparam string P  = (i == 0) ? "h4_" : "h1_";

    logic [2:0] vec;
    logic       gold;
    assign vec   = {aa[i], bb[i], cc[i]};
    assign gold  = (aa[i] & bb[i]) | cc[i];
    assign y1[i] = gold ^ y1_flip[i][vec];
    assign y2[i] = gold ^ y2_flip[i][vec];

    ao_vector_sequencer #(.HOLD_CYCLES(HC), .GOLDEN_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .start(start[i]), .abort(abort[i]),
      .y1(y1[i]), .y2(y2[i]), .aa(aa[i]), .bb(bb[i]), .cc(cc[i]),
      .busy(busy[i]), .done(done[i]), .fail(fail[i]),
      .mismatch_count(mcnt[i]), .fail_mask(fmask[i]), .first_fail_vec(ffv[i])
    );

    bit   prev_busy = 1'b0;
    bit   prev_fall = 1'b0;
    bit   seq_ok    = 1'b1;
    int   n         = 0;
    exp_t e;

    // Monitor: tracks edges since capture, checks the vector walk, and scores each run end.
    always @(negedge clk) begin
      if (prev_fall) checkOutput({P, "done_width"}, done[i], 0);
      prev_fall = 1'b0;
      if (busy[i]) begin
        if (!prev_busy) begin
          n      = 0;
          seq_ok = 1'b1;
        end else begin
          n++;
        end
        if (vec != 3'(n / HC) || done[i]) seq_ok = 1'b0;
      end else if (prev_busy) begin
        n++;
        prev_fall = 1'b1;
        if (exp_q.size() == 0) begin
          checkOutput({P, "unexpected_run_end"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput({P, "done"},           done[i], e.done);
          checkOutput({P, "fail"},           fail[i], e.fail);
          checkOutput({P, "mismatch_count"}, mcnt[i], e.cnt);
          checkOutput({P, "fail_mask"},      fmask[i], e.mask);
          checkOutput({P, "first_fail_vec"}, ffv[i], e.first);
          checkOutput({P, "latency"},        n, e.edges);
          checkOutput({P, "stim_idle"},      vec, 0);
          checkOutput({P, "vector_walk"},    seq_ok, 1);
        end
      end
      prev_busy = busy[i];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int errs;
    logic exp_busy, exp_done;
    rst = 1'b1;
    start = '0;
    abort = '0;
    y1_flip[0] = '0; y1_flip[1] = '0;
    y2_flip[0] = '0; y2_flip[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_flags", {aa[0], bb[0], cc[0], busy[0], done[0], fail[0]}, 0);
    checkOutput("reset_count", mcnt[0], 0);
    checkOutput("reset_mask",  fmask[0], 0);
    checkOutput("reset_first", ffv[0], 0);

    $display("[TB] clean run, extra start mid-run");
    pushExp(1, 0, 0, 8'h00, 0, 32);
    applyStimulus(0, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    waitIdle(0, 100);

    $display("[TB] y2 inverted on every vector");
    pushExp(1, 1, 8, 8'hFF, 0, 32);
    applyStimulus(0, 8'hFF, 1'b0);
    waitIdle(0, 100);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("hold_mask",  fmask[0], 8'hFF);
    checkOutput("hold_count", mcnt[0], 8);

    $display("[TB] y2 wrong on vectors 3 and 6");
    pushExp(1, 1, 2, 8'h48, 3, 32);
    applyStimulus(0, 8'h48, 1'b0);
    waitIdle(0, 100);
    @(negedge clk);
    abort[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort[0] = 1'b0;
    checkOutput("idle_abort_busy",  busy[0], 0);
    checkOutput("idle_abort_mask",  fmask[0], 8'h48);
    checkOutput("idle_abort_first", ffv[0], 3);

    $display("[TB] abort on the sample edge of vector 5");
    pushExp(0, 1, 1, 8'h04, 2, 24);
    applyStimulus(0, 8'h24, 1'b0);
    repeat (23) @(posedge clk);
    #1 abort[0] = 1'b1;
    @(posedge clk);
    #1 abort[0] = 1'b0;
    waitIdle(0, 100);

    $display("[TB] reset during vector 4 of a failing run");
    pushExp(0, 0, 0, 8'h00, 0, 18);
    applyStimulus(0, 8'hFF, 1'b0);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_rst_flags", {aa[0], bb[0], cc[0], busy[0], done[0], fail[0]}, 0);
    checkOutput("midrun_rst_count", mcnt[0], 0);
    checkOutput("midrun_rst_mask",  fmask[0], 0);
    rst = 1'b0;
    waitIdle(0, 100);
    pushExp(1, 0, 0, 8'h00, 0, 32);
    applyStimulus(0, 8'h00, 1'b0);
    waitIdle(0, 100);

    $display("[TB] start and abort together in IDLE");
    pushExp(1, 1, 1, 8'h80, 7, 32);
    applyStimulus(0, 8'h80, 1'b1);
    waitIdle(0, 100);

    $display("[TB] HOLD_CYCLES=1 with start held high");
    pushExp(1, 0, 0, 8'h00, 0, 8);
    pushExp(1, 0, 0, 8'h00, 0, 8);
    pushExp(1, 0, 0, 8'h00, 0, 8);
    errs = 0;
    @(negedge clk);
    start[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      exp_busy = (k % 10) < 8;
      exp_done = (k % 10) == 8;
      if (busy[1] !== exp_busy || done[1] !== exp_done) errs++;
    end
    start[1] = 1'b0;
    checkOutput("h1_back_to_back_timing", errs, 0);
    waitIdle(1, 50);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
